imem_port_arbiter: RTL

- Shares one single-port word memory between two requesters: the instruction-fetch port (read-only) and the load/store data port (read/write with byte enables).
- The memory has a 1-cycle registered read and a same-cycle byte-merged write. Its read data resets to 0.
- Sits between the core front-end/LSU and the memory. It owns grant, address/write muxing, response steering and out-of-range error flagging.

---
 rtl/imem_port_arbiter_pkg.sv | 19 +
 rtl/imem_port_arbiter_if.sv | 40 ++++
 rtl/imem_starve_ctr.sv | 43 ++++
 rtl/imem_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: response
// owner encoding, default parameters and the address range helper.
package imem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int ADD_WIDTH_DEF    = 17;
  localparam int STARVE_LIMIT_DEF = 4;

  // True when any address bit above the memory's byte-address width is set.
  function automatic logic addr_oor(input logic [31:0] add, input int unsigned aw);
    return (add >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals around the
// arbiter. The slave view is the arbiter itself; the master view is the
// surrounding core/memory environment.
interface imem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_add;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [31:0] d_add;
  logic [3:0]  d_wen;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] m_add;
  logic [3:0]  m_wen;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_add, d_req, d_add, d_wen, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_add, m_wen, m_wdata
  );

  modport master (
    output if_req, if_add, d_req, d_add, d_wen, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_add, m_wen, m_wdata
  );

endinterface

// File: rtl/imem_starve_ctr.sv
// Counts consecutive cycles the fetch port has been denied and flags when
// it has waited long enough to take priority over the data port.
module imem_starve_ctr
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic starve
);

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  // Saturating increment while fetch waits; any grant or idle fetch clears it.
  always_comb begin
    cnt_d = 4'd0;
    if (if_req && !if_gnt) begin
      if (cnt_q == 4'd15) begin
        cnt_d = 4'd15;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Counter register with synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q >= 4'(STARVE_LIMIT));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port word memory between instruction fetch and the
// load/store port: same-cycle grant, address/write muxing, range checking
// and steering of the 1-cycle-latency read response to its owner.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADD_WIDTH    = ADD_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  imem_port_arbiter_if.slave bus
);

  logic        starve;
  logic        if_gnt;
  logic        d_gnt;
  logic        if_oor;
  logic        d_oor;
  logic [31:0] m_add;
  logic [3:0]  m_wen;
  owner_e      owner_d;
  owner_e      owner_q;
  logic        oor_d;
  logic        oor_q;
  logic        if_rvalid;
  logic        d_rvalid;
  logic        d_err;
  logic [31:0] if_rdata;
  logic [31:0] d_rdata;

  imem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .if_req (bus.if_req),
    .if_gnt (if_gnt),
    .starve (starve)
  );

  // Grant: data by default, fetch once it has starved long enough.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end else if (bus.d_req && !(bus.if_req && starve)) begin
      d_gnt = 1'b1;
    end else if (bus.if_req) begin
      if_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
  end

  // Memory address mux and write enables; out-of-range writes never reach memory.
  always_comb begin
    if_oor = addr_oor(bus.if_add, int'(ADD_WIDTH));
    d_oor  = addr_oor(bus.d_add, int'(ADD_WIDTH));
    if (d_gnt) begin
      m_add = bus.d_add;
    end else begin
      m_add = bus.if_add;
    end
    if (d_gnt && !d_oor) begin
      m_wen = bus.d_wen;
    end else begin
      m_wen = 4'b0000;
    end
  end

  // Record who owns next cycle's memory read data and whether it was out of range.
  always_comb begin
    owner_d = OWN_NONE;
    oor_d   = 1'b0;
    if (d_gnt) begin
      owner_d = OWN_D;
      oor_d   = d_oor;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
      oor_d   = if_oor;
    end else begin
      owner_d = OWN_NONE;
      oor_d   = 1'b0;
    end
  end

  // Response ownership register; reset discards any response in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      oor_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      oor_q   <= oor_d;
    end
  end

  // Steer memory read data to the owner; the other port sees zero.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    if (reset) begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end else begin
      case (owner_q)
        OWN_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = oor_q ? 32'd0 : bus.m_rdata;
        end
        OWN_D: begin
          d_rvalid = 1'b1;
          d_err    = oor_q;
          d_rdata  = oor_q ? 32'd0 : bus.m_rdata;
        end
        default: begin
          if_rvalid = 1'b0;
          d_rvalid  = 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.m_add     = m_add;
  assign bus.m_wen     = m_wen;
  assign bus.m_wdata   = bus.d_wdata;
  assign bus.if_rvalid = if_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_err     = d_err;

endmodule
